rob_alloc_ctrl: RTL and testbench

ROB_ALLOC_CTRL -- requirements
Module: rob_alloc_ctrl

---
 rtl/rob_alloc_ctrl_pkg.sv | 15 +
 rtl/rob_alloc_ctrl.sv | 131 +++++++++++++
 tb/tb_rob_alloc_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared ROB definitions: default depth, entry id type and allocator FSM states.
package rob_alloc_ctrl_pkg;

    localparam int unsigned ROB_DEPTH = 64;
    localparam int unsigned ROB_ID_W  = $clog2(ROB_DEPTH);

    typedef logic [ROB_ID_W-1:0] rob_id_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        ACK   = 2'd2
    } rob_alloc_state_e;

endpackage

// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer allocation controller: two-lane allocate, prefix retire,
// circular head/tail/count bookkeeping and a timed flush/acknowledge sequence.
module rob_alloc_ctrl
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH        = ROB_DEPTH,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alloc_valid_i,
    input  logic [1:0]                      alloc_mask_i,
    output logic                            alloc_ready_o,
    output logic [1:0][$clog2(DEPTH)-1:0]   alloc_id_o,
    input  logic [1:0]                      retire_i,
    input  logic                            flush_i,
    output logic                            flush_ack_o,
    output logic [$clog2(DEPTH)-1:0]        head_o,
    output logic [$clog2(DEPTH)-1:0]        tail_o,
    output logic [$clog2(DEPTH):0]          count_o,
    output logic                            empty_o,
    output logic                            full_o,
    output logic                            err_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    rob_alloc_state_e state_q, state_d;
    logic [IW-1:0]    head_q, head_d;
    logic [IW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic             err_q, err_d;

    logic             fire;
    logic [1:0]       nalloc;
    logic [1:0]       retire_fix;
    logic [1:0]       nret_raw;
    logic [1:0]       nret;

    // Readiness looks only at registered occupancy so a full pair always fits.
    assign alloc_ready_o = (state_q == RUN) && !flush_i && (count_q <= CW'(DEPTH - 2));
    assign fire          = alloc_valid_i && alloc_ready_o;
    assign nalloc        = fire ? (2'(alloc_mask_i[0]) + 2'(alloc_mask_i[1])) : 2'd0;

    assign alloc_id_o[0] = tail_q;
    assign alloc_id_o[1] = tail_q + IW'(alloc_mask_i[0]);

    assign flush_ack_o = (state_q == ACK);
    assign head_o      = head_q;
    assign tail_o      = tail_q;
    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(DEPTH));
    assign err_o       = err_q;

    // Next-state and bookkeeping; a flush overrides every other update.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fcnt_d     = fcnt_q;
        err_d      = err_q;
        retire_fix = retire_i;
        nret_raw   = 2'd0;
        nret       = 2'd0;

        if (retire_i == 2'b10) begin
            retire_fix = 2'b01;
        end
        nret_raw = 2'(retire_fix[0]) + 2'(retire_fix[1]);
        nret     = nret_raw;
        if (CW'(nret_raw) > count_q) begin
            nret = 2'(count_q);
        end

        case (state_q)
            RUN: begin
                if ((retire_i == 2'b10) || (CW'(nret_raw) > count_q)) begin
                    err_d = 1'b1;
                end
                head_d  = head_q + IW'(nret);
                tail_d  = tail_q + IW'(nalloc);
                count_d = count_q + CW'(nalloc) - CW'(nret);
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    fcnt_d = fcnt_q - FW'(1);
                end
            end
            ACK: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (flush_i) begin
            state_d = FLUSH;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            fcnt_d  = FW'(FLUSH_CYCLES - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Bench for rob_alloc_ctrl: directed scenarios plus random traffic against a
// queue-based reference model of ROB occupancy and the flush sequence.
module tb_rob_alloc_ctrl;

    localparam int DEPTH        = 64;
    localparam int FLUSH_CYCLES = 2;
    localparam int IW           = $clog2(DEPTH);
    localparam int M_RUN        = 0;
    localparam int M_FLUSH      = 1;
    localparam int M_ACK        = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   alloc_valid_i;
    logic [1:0]             alloc_mask_i;
    logic                   alloc_ready_o;
    logic [1:0][IW-1:0]     alloc_id_o;
    logic [1:0]             retire_i;
    logic                   flush_i;
    logic                   flush_ack_o;
    logic [IW-1:0]          head_o;
    logic [IW-1:0]          tail_o;
    logic [IW:0]            count_o;
    logic                   empty_o;
    logic                   full_o;
    logic                   err_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: occupied ids in allocation order, plus flush progress.
    int m_q[$];
    int m_head, m_tail, m_err, m_mode, m_rem;

    rob_alloc_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid_i (alloc_valid_i),
        .alloc_mask_i  (alloc_mask_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_id_o    (alloc_id_o),
        .retire_i      (retire_i),
        .flush_i       (flush_i),
        .flush_ack_o   (flush_ack_o),
        .head_o        (head_o),
        .tail_o        (tail_o),
        .count_o       (count_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_head = 0;
        m_tail = 0;
        m_err  = 0;
        m_mode = M_RUN;
        m_rem  = 0;
    endtask

    task automatic check_regs();
        check("count", 32'(count_o), 32'(m_q.size()));
        check("head", 32'(head_o), 32'(m_head));
        check("tail", 32'(tail_o), 32'(m_tail));
        check("empty", 32'(empty_o), 32'(m_q.size() == 0));
        check("full", 32'(full_o), 32'(m_q.size() == DEPTH));
        check("err", 32'(err_o), 32'(m_err));
        check("ack", 32'(flush_ack_o), 32'(m_mode == M_ACK));
    endtask

    // One clock: drive at negedge, check combinational outputs, clock, check state.
    task automatic step(input logic v, input logic [1:0] m, input logic [1:0] r, input logic f);
        int exp_ready, nr;
        alloc_valid_i = v;
        alloc_mask_i  = m;
        retire_i      = r;
        flush_i       = f;
        #1;
        exp_ready = (m_mode == M_RUN && !f && m_q.size() <= DEPTH - 2) ? 1 : 0;
        check("ready", 32'(alloc_ready_o), 32'(exp_ready));
        check("id0", 32'(alloc_id_o[0]), 32'(m_tail));
        check("id1", 32'(alloc_id_o[1]), 32'((m_tail + int'(m[0])) % DEPTH));
        @(posedge clk);
        nr = 0;
        if (m_mode == M_RUN) begin
            nr = (r == 2'b10) ? 1 : int'(r[0]) + int'(r[1]);
            if (r == 2'b10) m_err = 1;
            if (nr > m_q.size()) begin
                m_err = 1;
                nr = m_q.size();
            end
        end
        if (f) begin
            m_mode = M_FLUSH;
            m_rem  = FLUSH_CYCLES;
            m_q.delete();
            m_head = 0;
            m_tail = 0;
        end else if (m_mode == M_RUN) begin
            repeat (nr) begin
                void'(m_q.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
            if (v && exp_ready == 1) begin
                for (int l = 0; l < 2; l++) begin
                    if (m[l]) begin
                        m_q.push_back(m_tail);
                        m_tail = (m_tail + 1) % DEPTH;
                    end
                end
            end
        end else if (m_mode == M_FLUSH) begin
            m_rem--;
            if (m_rem == 0) m_mode = M_ACK;
        end else begin
            m_mode = M_RUN;
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic flush_and_settle();
        step(1'b0, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 10 && m_mode != M_RUN; i++) step(1'b0, 2'b00, 2'b00, 1'b0);
    endtask

    initial begin
        int lat, acks;
        rst = 1'b1;
        alloc_valid_i = 1'b0;
        alloc_mask_i  = 2'b11;
        retire_i      = 2'b00;
        flush_i       = 1'b0;
        model_reset();
        #1;
        check("rst_ready", 32'(alloc_ready_o), 32'd1);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_ack", 32'(flush_ack_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_id0", 32'(alloc_id_o[0]), 32'd0);
        check("rst_id1", 32'(alloc_id_o[1]), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Fill with pairs up to 62 entries.
        repeat (31) step(1'b1, 2'b11, 2'b00, 1'b0);
        check("fill_count", 32'(count_o), 32'd62);
        check("fill_tail", 32'(tail_o), 32'd62);

        // Wrap allocate with simultaneous retire of two.
        alloc_valid_i = 1'b1; alloc_mask_i = 2'b11; retire_i = 2'b11; #1;
        check("wrap_id0", 32'(alloc_id_o[0]), 32'd62);
        check("wrap_id1", 32'(alloc_id_o[1]), 32'd63);
        check("wrap_ready", 32'(alloc_ready_o), 32'd1);
        step(1'b1, 2'b11, 2'b11, 1'b0);
        check("wrap_tail", 32'(tail_o), 32'd0);
        check("wrap_head", 32'(head_o), 32'd2);
        check("wrap_count", 32'(count_o), 32'd62);

        step(1'b1, 2'b11, 2'b00, 1'b0);
        check("full_count", 32'(count_o), 32'd64);
        check("full_flag", 32'(full_o), 32'd1);
        check("full_ready", 32'(alloc_ready_o), 32'd0);
        step(1'b1, 2'b11, 2'b00, 1'b0);

        // Single-lane masks.
        flush_and_settle();
        step(1'b1, 2'b11, 2'b00, 1'b0);
        step(1'b1, 2'b11, 2'b00, 1'b0);
        step(1'b1, 2'b01, 2'b00, 1'b0);
        check("lane_tail5", 32'(tail_o), 32'd5);
        alloc_valid_i = 1'b1; alloc_mask_i = 2'b10; #1;
        check("lane_id1", 32'(alloc_id_o[1]), 32'd5);
        step(1'b1, 2'b10, 2'b00, 1'b0);
        check("lane_tail6", 32'(tail_o), 32'd6);
        alloc_mask_i = 2'b01; #1;
        check("lane_id0", 32'(alloc_id_o[0]), 32'd6);
        step(1'b1, 2'b01, 2'b00, 1'b0);

        // Flush timing from count 20.
        flush_and_settle();
        repeat (10) step(1'b1, 2'b11, 2'b00, 1'b0);
        check("pre_flush_count", 32'(count_o), 32'd20);
        alloc_valid_i = 1'b1; alloc_mask_i = 2'b11; flush_i = 1'b1; #1;
        check("flush_ready", 32'(alloc_ready_o), 32'd0);
        step(1'b1, 2'b11, 2'b00, 1'b1);
        check("flush_count", 32'(count_o), 32'd0);
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            step(1'b0, 2'b00, 2'b00, 1'b0);
            if (flush_ack_o === 1'b1) lat = i + 1;
        end
        check("ack_latency", 32'(lat), 32'(FLUSH_CYCLES + 1));
        step(1'b0, 2'b00, 2'b00, 1'b0);
        check("post_ack", 32'(flush_ack_o), 32'd0);
        check("post_ack_ready", 32'(alloc_ready_o), 32'd1);

        // Re-flush one cycle into FLUSH: one ack, timed from the second pulse.
        step(1'b0, 2'b00, 2'b00, 1'b1);
        step(1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 2'b00, 2'b00, 1'b1);
        lat = 0;
        acks = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 2'b00, 2'b00, 1'b0);
            if (flush_ack_o === 1'b1) begin
                acks++;
                if (lat == 0) lat = i + 1;
            end
        end
        check("reflush_acks", 32'(acks), 32'd1);
        check("reflush_latency", 32'(lat), 32'(FLUSH_CYCLES + 1));

        // Over-retire sets a sticky error that survives a flush.
        check("err_clean", 32'(err_o), 32'd0);
        step(1'b1, 2'b01, 2'b00, 1'b0);
        step(1'b0, 2'b00, 2'b11, 1'b0);
        check("over_count", 32'(count_o), 32'd0);
        check("over_head", 32'(head_o), 32'd1);
        check("over_err", 32'(err_o), 32'd1);
        flush_and_settle();
        check("err_sticky", 32'(err_o), 32'd1);

        // Reset in the middle of FLUSH: back to RUN with no ack.
        step(1'b0, 2'b00, 2'b00, 1'b1);
        step(1'b0, 2'b00, 2'b00, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check("rstf_ack", 32'(flush_ack_o), 32'd0);
        check("rstf_err", 32'(err_o), 32'd0);
        check("rstf_ready", 32'(alloc_ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 2'b00, 2'b00, 1'b0);
            if (flush_ack_o === 1'b1) acks++;
        end
        check("rstf_no_ack", 32'(acks), 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic       v, f;
            logic [1:0] m, r;
            v = ($urandom % 4) != 0;
            m = 2'($urandom);
            r = (($urandom % 3) == 0) ? 2'($urandom) : 2'b00;
            if (r == 2'b10 && ($urandom % 4) != 0) r = 2'b01;
            f = ($urandom % 40) == 0;
            step(v, m, r, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
